// File: rtl/sinegen_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// sinegen_sweep_ctrl: stepped-frequency sweep sequencer for the sine generator
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sinegen_sweep_ctrl #(
  parameter int WIDTH   = 8,
  parameter int DWELL_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [WIDTH-1:0]   start_incr,
  input  logic [WIDTH-1:0]   stop_incr,
  input  logic [WIDTH-1:0]   step,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               loop,
  output logic [WIDTH-1:0]   incr,
  output logic               en,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state, state_nx;
  logic [WIDTH-1:0]   incr_nx;
  logic               en_nx, busy_nx, done_nx;
  logic [DWELL_W-1:0] cnt, cnt_nx;

  logic [WIDTH-1:0]   cfg_start, cfg_stop, cfg_step;
  logic [DWELL_W-1:0] cfg_dwell;
  logic               cfg_loop, cfg_up;
  logic [WIDTH-1:0]   cfg_start_nx, cfg_stop_nx, cfg_step_nx;
  logic [DWELL_W-1:0] cfg_dwell_nx;
  logic               cfg_loop_nx, cfg_up_nx;

  // One extra bit lets the clamp detect overshoot past stop or below zero.
  logic [WIDTH:0]     sum_ext, diff_ext, stop_ext;
  logic [WIDTH-1:0]   stepped;

  assign stop_ext = {1'b0, cfg_stop};
  assign sum_ext  = {1'b0, incr} + {1'b0, cfg_step};
  assign diff_ext = {1'b0, incr} - {1'b0, cfg_step};

  always_comb begin
    stepped = cfg_stop;
    if (cfg_up) begin
      if (sum_ext < stop_ext) stepped = sum_ext[WIDTH-1:0];
    end else begin
      if (!diff_ext[WIDTH] && (diff_ext > stop_ext)) stepped = diff_ext[WIDTH-1:0];
    end
  end

  always_comb begin
    state_nx     = state;
    incr_nx      = incr;
    cnt_nx       = cnt;
    en_nx        = 1'b0;
    busy_nx      = 1'b0;
    done_nx      = 1'b0;
    cfg_start_nx = cfg_start;
    cfg_stop_nx  = cfg_stop;
    cfg_step_nx  = cfg_step;
    cfg_dwell_nx = cfg_dwell;
    cfg_loop_nx  = cfg_loop;
    cfg_up_nx    = cfg_up;

    case (state)
      IDLE: begin
        if (start) begin
          state_nx     = RUN;
          incr_nx      = start_incr;
          cnt_nx       = dwell;
          en_nx        = 1'b1;
          busy_nx      = 1'b1;
          cfg_start_nx = start_incr;
          cfg_stop_nx  = stop_incr;
          cfg_step_nx  = (step == '0) ? WIDTH'(1) : step;
          cfg_dwell_nx = dwell;
          cfg_loop_nx  = loop;
          cfg_up_nx    = (stop_incr >= start_incr);
        end
      end

      RUN: begin
        if (abort) begin
          state_nx = IDLE;
        end else begin
          en_nx   = 1'b1;
          busy_nx = 1'b1;
          if (cnt != '0) begin
            cnt_nx = cnt - DWELL_W'(1);
          end else if (incr != cfg_stop) begin
            incr_nx = stepped;
            cnt_nx  = cfg_dwell;
          end else if (cfg_loop) begin
            incr_nx = cfg_start;
            cnt_nx  = cfg_dwell;
          end else begin
            state_nx = DONE;
            en_nx    = 1'b0;
            busy_nx  = 1'b0;
            done_nx  = 1'b1;
          end
        end
      end

      DONE: begin
        state_nx = IDLE;
      end

      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      incr      <= '0;
      en        <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cnt       <= '0;
      cfg_start <= '0;
      cfg_stop  <= '0;
      cfg_step  <= '0;
      cfg_dwell <= '0;
      cfg_loop  <= 1'b0;
      cfg_up    <= 1'b0;
    end else begin
      state     <= state_nx;
      incr      <= incr_nx;
      en        <= en_nx;
      busy      <= busy_nx;
      done      <= done_nx;
      cnt       <= cnt_nx;
      cfg_start <= cfg_start_nx;
      cfg_stop  <= cfg_stop_nx;
      cfg_step  <= cfg_step_nx;
      cfg_dwell <= cfg_dwell_nx;
      cfg_loop  <= cfg_loop_nx;
      cfg_up    <= cfg_up_nx;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sinegen_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sinegen_sweep_ctrl: directed + randomized bench for sinegen_sweep_ctrl
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_sinegen_sweep_ctrl;

  logic        clk = 1'b0;
  logic        rst, start, abort, loop;
  logic [7:0]  start_incr, stop_incr, step;
  logic [15:0] dwell;
  logic [7:0]  incr;
  logic        en, busy, done;

  int passed = 0;
  int total  = 0;
  int exp_q[$];

  sinegen_sweep_ctrl #(.WIDTH(8), .DWELL_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .start_incr(start_incr), .stop_incr(stop_incr), .step(step),
    .dwell(dwell), .loop(loop),
    .incr(incr), .en(en), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // Expected incr trace of one pass: every visited value repeated dwell+1 times.
  task automatic build(input int s, input int e, input int st, input int dw);
    int v, d;
    exp_q.delete();
    d = (st == 0) ? 1 : st;
    v = s;
    forever begin
      for (int k = 0; k <= dw; k++) exp_q.push_back(v);
      if (v == e) break;
      if (e >= s) v = (v + d > e) ? e : v + d;
      else        v = (v - d < e) ? e : v - d;
    end
  endtask

  task automatic scramble_inputs();
    start      = 1'($urandom);
    start_incr = 8'($urandom);
    stop_incr  = 8'($urandom);
    step       = 8'($urandom);
    dwell      = 16'($urandom_range(0, 5));
    loop       = 1'($urandom);
  endtask

  // loop_cycles > 0 runs a looping sweep for that many cycles then aborts.
  task automatic sweep(input string tag, input int s, input int e, input int st,
                       input int dw, input bit lp, input bit ab_start,
                       input bit perturb, input int loop_cycles);
    build(s, e, st, dw);
    start_incr = 8'(s); stop_incr = 8'(e); step = 8'(st);
    dwell = 16'(dw); loop = lp; abort = ab_start; start = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    if (loop_cycles > 0) begin
      for (int i = 0; i < loop_cycles; i++) begin
        check({tag, ".incr"}, 32'(incr), 32'(exp_q[i % exp_q.size()]));
        check({tag, ".en"},   32'(en),   32'd1);
        check({tag, ".done"}, 32'(done), 32'd0);
        if (perturb) scramble_inputs();
        tick();
      end
      start = 1'b0;
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check({tag, ".abort_en"},   32'(en),   32'd0);
      check({tag, ".abort_busy"}, 32'(busy), 32'd0);
      check({tag, ".abort_done"}, 32'(done), 32'd0);
      tick();
      check({tag, ".abort_idle"}, 32'({en, done}), 32'd0);
    end else begin
      foreach (exp_q[i]) begin
        check({tag, ".incr"}, 32'(incr), 32'(exp_q[i]));
        check({tag, ".en"},   32'(en),   32'd1);
        check({tag, ".busy"}, 32'(busy), 32'd1);
        check({tag, ".done"}, 32'(done), 32'd0);
        if (perturb) scramble_inputs();
        tick();
      end
      check({tag, ".done_pulse"}, 32'(done), 32'd1);
      check({tag, ".done_en"},    32'(en),   32'd0);
      check({tag, ".done_busy"},  32'(busy), 32'd0);
      check({tag, ".done_incr"},  32'(incr), 32'(e));
      start = 1'b0;
      tick();
      check({tag, ".idle_done"}, 32'(done), 32'd0);
      check({tag, ".idle_en"},   32'(en),   32'd0);
      check({tag, ".idle_incr"}, 32'(incr), 32'(e));
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; loop = 1'b0;
    start_incr = '0; stop_incr = '0; step = '0; dwell = '0;
    tick(); tick();
    check("reset.incr", 32'(incr), 32'd0);
    check("reset.ctl",  32'({en, busy, done}), 32'd0);
    rst = 1'b0;
    tick();
    check("idle.en", 32'(en), 32'd0);

    // Reset mid-sweep, then a normal sweep afterwards.
    start_incr = 8'd50; stop_incr = 8'd60; step = 8'd1; dwell = 16'd1; loop = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick(); tick();
    check("midrst.pre_en", 32'(en), 32'd1);
    rst = 1'b1; tick(); rst = 1'b0;
    check("midrst.incr", 32'(incr), 32'd0);
    check("midrst.ctl",  32'({en, busy, done}), 32'd0);
    tick();
    check("midrst.stays_idle", 32'(en), 32'd0);

    sweep("up",        1,   4,   1, 2, 1'b0, 1'b0, 1'b0, 0);
    sweep("down_clamp",200, 190, 4, 0, 1'b0, 1'b0, 1'b0, 0);
    sweep("down_step0",200, 190, 0, 0, 1'b0, 1'b0, 1'b0, 0);
    sweep("loop",      10,  12,  1, 1, 1'b1, 1'b0, 1'b0, 15);
    sweep("ignore_in", 20,  30,  3, 1, 1'b0, 1'b0, 1'b1, 0);
    sweep("equal",     7,   7,   5, 3, 1'b0, 1'b0, 1'b0, 0);
    sweep("start_abort", 100, 103, 1, 0, 1'b0, 1'b1, 1'b0, 0);
    sweep("up_clamp_top", 250, 255, 4, 0, 1'b0, 1'b0, 1'b0, 0);
    sweep("down_zero", 5,   0,   3, 1, 1'b0, 1'b0, 1'b0, 0);

    for (int r = 0; r < 8; r++) begin
      sweep("rand", int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
            int'($urandom_range(0, 40)), int'($urandom_range(0, 3)),
            1'b0, 1'($urandom), 1'b1, 0);
    end
    sweep("rand_loop", int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
          int'($urandom_range(8, 60)), int'($urandom_range(0, 2)), 1'b1, 1'b0, 1'b1, 120);

    // abort while idle must not disturb anything
    abort = 1'b1; tick(); abort = 1'b0;
    check("abort_idle.ctl", 32'({en, busy, done}), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/sinegen_sweep_ctrl.md
Name: sinegen_sweep_ctrl

Overview:
- Sequencer that drives the `incr` (phase step) and `en` inputs of the sine generator to produce a stepped frequency sweep.
- Steps `incr` from a start value to a stop value, in either direction, holding each value for a programmable dwell.
- Optionally loops the sweep; otherwise it ends with a one-cycle done pulse.
- Sits between the top-level control inputs (switches/testbench) and the sine generator instance.

Parameters:
- WIDTH, 8, width of `incr` and the sweep configuration values; matches the sine generator WIDTH.
- DWELL_W, 16, width of the dwell counter and the `dwell` input.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  single-cycle request to begin a sweep; honoured only in IDLE.
- abort  input  1  stop the sweep immediately; no done pulse.
- start_incr  input  WIDTH  first increment value.
- stop_incr  input  WIDTH  final increment value.
- step  input  WIDTH  increment delta per dwell period; 0 treated as 1.
- dwell  input  DWELL_W  each increment value is held for dwell+1 cycles.
- loop  input  1  1 = restart from start_incr after the stop dwell expires.
- incr  output  WIDTH  to sine generator incr.
- en  output  1  to sine generator en.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse on normal completion.

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=IDLE; incr=0, en=0, busy=0, done=0.
  - Dwell counter and latched configuration cleared.
  - Reset wins over every other input, including mid-sweep.
- States: IDLE, RUN, DONE.
- Configuration capture:
  - start_incr, stop_incr, step (0 mapped to 1), dwell and loop are latched on the accepting start edge.
  - Later input changes have no effect until the next accepted start.
  - Direction is fixed at latch time: up if stop_incr >= start_incr, else down.
- IDLE:
  - en=0, busy=0; incr holds its last value (0 after reset).
  - On start=1: next cycle state=RUN, incr=start_incr, en=1, busy=1, dwell counter=dwell.
- RUN, at each edge (unless abort):
  - If dwell counter != 0: decrement it; incr unchanged.
  - If dwell counter == 0 and incr != stop:
    - Up: incr = min(incr+step, stop). Down: incr = max(incr-step, stop).
    - Arithmetic in WIDTH+1 bits; never wraps or overshoots stop.
    - Counter reloads to dwell.
  - If dwell counter == 0 and incr == stop:
    - loop=1: incr=start (latched), counter=dwell, stay in RUN.
    - loop=0: state=DONE, en=0, busy=0.
  - start is ignored in RUN.
- DONE: done=1 for exactly this cycle, en=0; next edge goes to IDLE. start is ignored in DONE.
- abort=1 in RUN or DONE: next cycle IDLE, en=0, busy=0, done=0. abort in IDLE has no effect.
- abort and start asserted together:
  - In IDLE, start is accepted.
  - In RUN, abort wins.
- start_incr == stop_incr: single value held dwell+1 cycles, then DONE (or repeat if loop=1).
- Timing: en/incr change 1 cycle after the accepting start edge. Total RUN cycles for a non-looped sweep = N×(dwell+1), where N = number of distinct incr values visited.
- All outputs are registered; no combinational input-to-output path.

Test Plan:
- Reset mid-sweep: assert rst during RUN -> next cycle incr=0, en=0, busy=0, done=0, state IDLE; a later start works normally.
- Up sweep: start=1, start_incr=1, stop_incr=4, step=1, dwell=2, loop=0 -> incr sequence 1,1,1,2,2,2,3,3,3,4,4,4 with en=1 for 12 cycles; then done=1 for one cycle, en=0; busy falls with en.
- Clamp, down, step=0:
  - start_incr=200, stop_incr=190, step=4, dwell=0 -> incr 200,196,192,190, then done; no value below 190.
  - Repeat with step=0 -> step of 1, 11 RUN cycles.
- Loop and abort: start_incr=10, stop_incr=12, step=1, dwell=1, loop=1 -> 10,10,11,11,12,12,10,10,... with no done. Assert abort -> next cycle en=0, busy=0, done never asserted.
- Start ignored while busy: during RUN, pulse start with different start_incr -> sweep continues on the latched config. Change stop_incr input mid-sweep -> no effect.
- Equal endpoints and simultaneous inputs:
  - start_incr=stop_incr=7, dwell=3 -> incr=7 for 4 cycles, then done.
  - start+abort in IDLE -> sweep starts.
